mem_ifetch: RTL

- Instruction-fetch side of the memory controller: on an icache miss it reads the instruction bytes from the byte-wide RAM.
- Assembles 16-bit (compressed) or 32-bit instructions.
- Presents the result on the mem_inst_ready / mem_inst / mem_inst_addr triple that the icache consumes to fill its lines.
- Sits between the Fetcher/icache pair and the RAM bus arbiter.

---
 rtl/mem_ifetch_pkg.sv | 18 +
 rtl/mem_ifetch_if.sv | 32 +++
 rtl/mem_ifetch_assembler.sv | 65 ++++++
 rtl/mem_ifetch.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mem_ifetch_pkg.sv
// Shared types and constants for the instruction-fetch memory port.
package mem_ifetch_pkg;

  localparam int XLEN       = 32;
  // The RAM answers one cycle after the address; no other latency is handled.
  localparam int RAM_RD_LAT = 1;

  localparam logic [2:0] INST_BYTES_C    = 3'd2;
  localparam logic [2:0] INST_BYTES_FULL = 3'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    READ     = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/mem_ifetch_if.sv
// Fetcher/icache request, RAM bus and icache fill signals of the fetch port.
interface mem_ifetch_if;
  import mem_ifetch_pkg::*;

  // bus_req is held from acceptance until the last byte is captured and the
  // arbiter keeps bus_grant high meanwhile; mem_inst_ready is the fill valid,
  // held with mem_inst/mem_inst_addr until a cycle with !stall && !flush.
  logic            fet_req;
  logic [XLEN-1:0] fet_pc;
  logic            bus_grant;
  logic            bus_req;
  logic [7:0]      mem_din;
  logic [XLEN-1:0] mem_a;
  logic            mem_wr;
  logic [7:0]      mem_dout;
  logic            mem_inst_ready;
  logic [XLEN-1:0] mem_inst;
  logic [XLEN-1:0] mem_inst_addr;

  modport master (
    input  fet_req, fet_pc, bus_grant, mem_din,
    output bus_req, mem_a, mem_wr, mem_dout,
    output mem_inst_ready, mem_inst, mem_inst_addr
  );

  modport slave (
    output fet_req, fet_pc, bus_grant, mem_din,
    input  bus_req, mem_a, mem_wr, mem_dout,
    input  mem_inst_ready, mem_inst, mem_inst_addr
  );

endinterface

// File: rtl/mem_ifetch_assembler.sv
// Byte counter, little-endian word assembly and instruction-length decision.
// MEM_IFETCH_C_EXT_EN enables 2-byte compressed fetches; otherwise 4 bytes always.
module mem_byte_assembler
  import mem_ifetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            active_i,
  input  logic            capture_i,
  input  logic [7:0]      din_i,
  output logic            last_o,
  output logic [2:0]      need_o,
  output logic [XLEN-1:0] word_o
);

  logic [2:0]      cnt_q, cnt_d;
  logic [2:0]      need_q, need_d;
  logic [2:0]      need_now;
  logic [XLEN-1:0] word_q, word_d;

  always_comb begin
    need_now = need_q;
`ifdef MEM_IFETCH_C_EXT_EN
    if (cnt_q == 3'd0) begin
      need_now = (din_i[1:0] != 2'b11) ? INST_BYTES_C : INST_BYTES_FULL;
    end
`endif
    last_o = capture_i && ((cnt_q + 3'd1) == need_now);
    cnt_d  = cnt_q;
    need_d = need_q;
    word_d = word_q;
    if (!active_i) begin
      cnt_d  = 3'd0;
      need_d = INST_BYTES_FULL;
    end else if (capture_i) begin
      cnt_d  = cnt_q + 3'd1;
      need_d = need_now;
      // Byte 0 clears the word so a compressed result has a zero upper half.
      if (cnt_q == 3'd0) begin
        word_d = {{(XLEN-8){1'b0}}, din_i};
      end else begin
        word_d[{cnt_q[1:0], 3'b000} +: 8] = din_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        cnt_q  <= 3'd0;
        need_q <= INST_BYTES_FULL;
        word_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        need_q <= need_d;
        word_q <= word_d;
      end
    end
  end

  assign need_o = need_q;
  assign word_o = word_q;

endmodule

// File: rtl/mem_ifetch.sv
// Instruction-fetch RAM reader: bus request/grant FSM, address issue and icache fill.
module mem_ifetch
  import mem_ifetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic         stall,
  mem_ifetch_if.master bus,
  output state_t       dbg_state_o
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] mem_a_q;
  logic [2:0]      iss_q, iss_d;
  logic            issue;
  logic [XLEN-1:0] issue_addr;
  logic            accept;
  logic            bus_req;
  logic            asm_last;
  logic [2:0]      asm_need;
  logic [XLEN-1:0] asm_word;

  assign accept = rdy && bus.fet_req && !flush;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    iss_d      = iss_q;
    issue      = 1'b0;
    issue_addr = pc_q;
    bus_req    = 1'b0;
    case (state_q)
      IDLE: begin
        bus_req = accept;
        if (bus.fet_req && !flush) pc_d = bus.fet_pc;
        if (accept) begin
          if (bus.bus_grant) begin
            state_d    = READ;
            issue      = 1'b1;
            issue_addr = bus.fet_pc;
            iss_d      = 3'd1;
          end else begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        bus_req = 1'b1;
        if (bus.bus_grant && rdy) begin
          state_d = READ;
          issue   = 1'b1;
          iss_d   = 3'd1;
        end
      end
      READ: begin
        bus_req = 1'b1;
        if (iss_q < asm_need) begin
          issue      = 1'b1;
          issue_addr = pc_q + {{(XLEN-3){1'b0}}, iss_q};
          iss_d      = iss_q + 3'd1;
        end
        if (asm_last) begin
          state_d = DONE;
          addr_d  = pc_q;
        end
      end
      DONE: begin
        if (!stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      if (rst) begin
        state_q <= IDLE;
        pc_q    <= '0;
        addr_q  <= '0;
        mem_a_q <= '0;
        iss_q   <= 3'd0;
      end else begin
        state_q <= state_d;
        pc_q    <= pc_d;
        addr_q  <= addr_d;
        mem_a_q <= bus.mem_a;
        iss_q   <= iss_d;
      end
    end
  end

  // Every READ cycle carries the byte addressed one cycle earlier.
  mem_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .active_i  (state_q == READ),
    .capture_i ((state_q == READ) && !flush),
    .din_i     (bus.mem_din),
    .last_o    (asm_last),
    .need_o    (asm_need),
    .word_o    (asm_word)
  );

  assign bus.bus_req        = bus_req;
  assign bus.mem_a          = issue ? issue_addr : mem_a_q;
  assign bus.mem_wr         = 1'b0;
  assign bus.mem_dout       = 8'h00;
  assign bus.mem_inst_ready = (state_q == DONE);
  assign bus.mem_inst       = asm_word;
  assign bus.mem_inst_addr  = addr_q;
  assign dbg_state_o        = state_q;

endmodule
